// File: rtl/ho2mx_rx_splitter_if.sv
// AXI-stream style channel bundle used for the merged RX input and the RX / RXREQ outputs.
// The master drives the beat fields and the slave returns tready.
interface ho2mx_rx_splitter_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser_vendor;

    modport master (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
endinterface

// File: rtl/ho2mx_rx_splitter.sv
// Host-to-AFU RX steering: classifies each packet at SOP as request or other and delivers it,
// beat by beat, through a registered 2-entry skid buffer on the chosen output with packet counters.

module ho2mx_rx_skid #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    input  logic [USER_W-1:0]   in_user,
    output logic [1:0]          cnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last,
    output logic [USER_W-1:0]   out_user,
    output logic [CNT_W-1:0]    pkt_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int ENT_W  = DATA_W + KEEP_W + 1 + USER_W;

    logic [ENT_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d, in_ent_s;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             deq_s;

    // Next-state: entry 0 is always the head; entry 1 only holds the second beat when full.
    always_comb begin
        in_ent_s  = {in_last, in_user, in_keep, in_data};
        deq_s     = (cnt_q != 2'd0) && out_ready;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        cnt_d     = cnt_q;
        case ({enq, deq_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = in_ent_s;
                end else begin
                    ent1_d = in_ent_s;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = in_ent_s;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_ent_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        if (deq_s && ent0_q[ENT_W-1]) begin
            pkt_cnt_d = pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Buffer storage, occupancy and delivered-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q    <= {ENT_W{1'b0}};
            ent1_q    <= {ENT_W{1'b0}};
            cnt_q     <= 2'd0;
            pkt_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q[DATA_W-1:0];
    assign out_keep  = ent0_q[DATA_W +: KEEP_W];
    assign out_user  = ent0_q[DATA_W+KEEP_W +: USER_W];
    assign out_last  = ent0_q[ENT_W-1];
    assign pkt_cnt   = pkt_cnt_q;
endmodule

module ho2mx_rx_splitter #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ho2mx_rx_splitter_if.slave    in_if,
    ho2mx_rx_splitter_if.master   req_if,
    ho2mx_rx_splitter_if.master   cpl_if,
    output logic [CNT_W-1:0]      req_pkt_cnt,
    output logic [CNT_W-1:0]      cpl_pkt_cnt
);
    localparam logic ROUTE_REQ = 1'b1;
    localparam logic ROUTE_CPL = 1'b0;

    logic       sop_q, sop_d, route_q, route_d;
    logic       is_req_s, eff_route_s, in_tready_s, accept_s, enq_req_s, enq_cpl_s;
    logic [1:0] req_cnt_s, cpl_cnt_s;

    // Host requests are the memory read/write family: fmt_type[4:0] is zero in both PU and DM encodings.
    always_comb begin
        is_req_s    = in_if.tvalid && (in_if.tdata[28:24] == 5'b00000);
        eff_route_s = sop_q ? is_req_s : route_q;
        if (eff_route_s == ROUTE_REQ) begin
            in_tready_s = !rst && (req_cnt_s != 2'd2);
        end else begin
            in_tready_s = !rst && (cpl_cnt_s != 2'd2);
        end
        accept_s  = in_if.tvalid && in_tready_s;
        enq_req_s = accept_s && (eff_route_s == ROUTE_REQ);
        enq_cpl_s = accept_s && (eff_route_s == ROUTE_CPL);
        sop_d     = accept_s ? in_if.tlast : sop_q;
        route_d   = (accept_s && sop_q) ? is_req_s : route_q;
    end

    // SOP tracker and per-packet route hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sop_q   <= 1'b1;
            route_q <= ROUTE_CPL;
        end else begin
            sop_q   <= sop_d;
            route_q <= route_d;
        end
    end

    assign in_if.tready = in_tready_s;

    ho2mx_rx_skid #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) u_req_skid (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq_req_s),
        .in_data   (in_if.tdata),
        .in_keep   (in_if.tkeep),
        .in_last   (in_if.tlast),
        .in_user   (in_if.tuser_vendor),
        .cnt       (req_cnt_s),
        .out_valid (req_if.tvalid),
        .out_ready (req_if.tready),
        .out_data  (req_if.tdata),
        .out_keep  (req_if.tkeep),
        .out_last  (req_if.tlast),
        .out_user  (req_if.tuser_vendor),
        .pkt_cnt   (req_pkt_cnt)
    );

    ho2mx_rx_skid #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) u_cpl_skid (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq_cpl_s),
        .in_data   (in_if.tdata),
        .in_keep   (in_if.tkeep),
        .in_last   (in_if.tlast),
        .in_user   (in_if.tuser_vendor),
        .cnt       (cpl_cnt_s),
        .out_valid (cpl_if.tvalid),
        .out_ready (cpl_if.tready),
        .out_data  (cpl_if.tdata),
        .out_keep  (cpl_if.tkeep),
        .out_last  (cpl_if.tlast),
        .out_user  (cpl_if.tuser_vendor),
        .pkt_cnt   (cpl_pkt_cnt)
    );
endmodule

// File: tb/tb_ho2mx_rx_splitter.sv
// Randomized bench for ho2mx_rx_splitter: a packet-level model routes each packet by its
// SOP fmt_type and predicts per-output beat order and delivered-packet counts.
module tb_ho2mx_rx_splitter;
    localparam int DW = 512;
    localparam int UW = 10;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) in_if ();
    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) req_if ();
    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) cpl_if ();
    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) in4_if ();
    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) req4_if ();
    ho2mx_rx_splitter_if #(.DATA_W(DW), .USER_W(UW)) cpl4_if ();

    logic [31:0] req_cnt, cpl_cnt;
    logic [3:0]  req_cnt4, cpl_cnt4;

    ho2mx_rx_splitter #(.DATA_W(DW), .USER_W(UW), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_if(in_if), .req_if(req_if), .cpl_if(cpl_if),
        .req_pkt_cnt(req_cnt), .cpl_pkt_cnt(cpl_cnt)
    );

    ho2mx_rx_splitter #(.DATA_W(DW), .USER_W(UW), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_if(in4_if), .req_if(req4_if), .cpl_if(cpl4_if),
        .req_pkt_cnt(req_cnt4), .cpl_pkt_cnt(cpl_cnt4)
    );

    beat_t exp_req[$], exp_cpl[$], obs_req[$], obs_cpl[$];
    int total = 0, bad = 0, stalls = 0;
    int exp_req_n = 0, exp_cpl_n = 0, req4_seen = 0;
    bit rand_done;

    // Records every beat that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && req_if.tvalid && req_if.tready)
            obs_req.push_back({req_if.tdata, req_if.tkeep, req_if.tlast, req_if.tuser_vendor});
        if (!rst && cpl_if.tvalid && cpl_if.tready)
            obs_cpl.push_back({cpl_if.tdata, cpl_if.tkeep, cpl_if.tlast, cpl_if.tuser_vendor});
        if (!rst && req4_if.tvalid && req4_if.tready)
            req4_seen++;
    end

    function automatic beat_t rand_beat(input logic [7:0] ft, input bit first, input bit last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.k = {$urandom, $urandom};
        b.u = UW'($urandom);
        b.l = last;
        if (first) b.d[31:24] = ft;
        return b;
    endfunction

    task automatic clear_sb();
        exp_req.delete(); exp_cpl.delete(); obs_req.delete(); obs_cpl.delete();
    endtask

    task automatic drain();
        req_if.tready = 1'b1;
        cpl_if.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Sends one packet; the model routes the whole packet by its first beat's fmt_type.
    task automatic send_pkt(input logic [7:0] ft, input int nb);
        bit to_req;
        beat_t b;
        int w;
        to_req = (ft[4:0] == 5'd0);
        for (int i = 0; i < nb; i++) begin
            b = rand_beat(ft, i == 0, i == nb - 1);
            in_if.tvalid = 1'b1; in_if.tdata = b.d; in_if.tkeep = b.k;
            in_if.tlast = b.l; in_if.tuser_vendor = b.u;
            @(negedge clk);
            w = 0;
            while (!in_if.tready && w < 200) begin w++; stalls++; @(negedge clk); end
            total++;
            if (w >= 200) begin bad++; $display("FAIL accept_timeout ft=%h got=stalled want=accepted", ft); end
            if (to_req) exp_req.push_back(b); else exp_cpl.push_back(b);
            @(posedge clk); #1;
        end
        in_if.tvalid = 1'b0;
        if (to_req) exp_req_n++; else exp_cpl_n++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_if.tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", in_if.tready); end
        total++; if ({req_if.tvalid, cpl_if.tvalid} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", {req_if.tvalid, cpl_if.tvalid}); end
        total++; if (req_cnt !== 32'd0 || cpl_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", req_cnt, cpl_cnt); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_if.tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready got=%b want=1", in_if.tready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_mrd();
        clear_sb();
        send_pkt(8'h20, 1);
        total++; if (req_if.tvalid !== 1'b1) begin bad++; $display("FAIL mrd_latency got=%b want=1", req_if.tvalid); end
        total++; if (req_if.tdata !== exp_req[0].d) begin bad++; $display("FAIL mrd_data got=%h want=%h", req_if.tdata[63:0], exp_req[0].d[63:0]); end
        total++; if (cpl_if.tvalid !== 1'b0) begin bad++; $display("FAIL mrd_cpl_idle got=%b want=0", cpl_if.tvalid); end
        drain();
        total++; if (req_cnt !== exp_req_n) begin bad++; $display("FAIL mrd_cnt got=%0d want=%0d", req_cnt, exp_req_n); end
    endtask

    task automatic test_cpld_then_mwr();
        clear_sb();
        send_pkt(8'h4A, 4);
        send_pkt(8'h40, 1);
        drain();
        total++; if (obs_cpl.size() != 4 || obs_req.size() != 1) begin bad++; $display("FAIL split_sizes got=%0d/%0d want=4/1", obs_cpl.size(), obs_req.size()); end
        for (int i = 0; i < obs_cpl.size() && i < exp_cpl.size(); i++) begin
            total++; if (obs_cpl[i] !== exp_cpl[i]) begin bad++; $display("FAIL split_cpl%0d got=%h want=%h", i, obs_cpl[i].d[63:0], exp_cpl[i].d[63:0]); end
        end
        total++; if (obs_req.size() > 0 && obs_req[0] !== exp_req[0]) begin bad++; $display("FAIL split_req got=%h want=%h", obs_req[0].d[63:0], exp_req[0].d[63:0]); end
        total++; if (req_cnt !== exp_req_n || cpl_cnt !== exp_cpl_n) begin bad++; $display("FAIL split_cnt got=%0d/%0d want=%0d/%0d", req_cnt, cpl_cnt, exp_req_n, exp_cpl_n); end
    endtask

    task automatic test_backpressure();
        beat_t b;
        int w;
        clear_sb();
        req_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b = rand_beat(8'h00, 1'b1, 1'b1);
            in_if.tvalid = 1'b1; in_if.tdata = b.d; in_if.tkeep = b.k;
            in_if.tlast = b.l; in_if.tuser_vendor = b.u;
            exp_req.push_back(b);
            @(negedge clk);
            if (k < 2) begin
                total++; if (in_if.tready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%b want=1", k, in_if.tready); end
                @(posedge clk); #1;
            end
        end
        total++; if (in_if.tready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_if.tready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (in_if.tready !== 1'b0 || req_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b%b want=01", in_if.tready, req_if.tvalid); end
        total++; if (req_if.tdata !== exp_req[0].d || obs_req.size() != 0) begin bad++; $display("FAIL bp_head got=%h want=%h", req_if.tdata[63:0], exp_req[0].d[63:0]); end
        @(posedge clk); #1;
        req_if.tready = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_if.tready && w < 20) begin w++; @(negedge clk); end
        total++; if (w >= 20) begin bad++; $display("FAIL bp_release got=stalled want=accepted"); end
        @(posedge clk); #1;
        in_if.tvalid = 1'b0;
        exp_req_n += 3;
        drain();
        total++; if (obs_req.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", obs_req.size()); end
        for (int i = 0; i < obs_req.size() && i < 3; i++) begin
            total++; if (obs_req[i] !== exp_req[i]) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", i, obs_req[i].d[63:0], exp_req[i].d[63:0]); end
        end
        total++; if (req_cnt !== exp_req_n) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", req_cnt, exp_req_n); end
    endtask

    task automatic test_back_to_back();
        int s0;
        clear_sb();
        s0 = stalls;
        for (int i = 0; i < 100; i++) send_pkt((i % 2 == 0) ? 8'h0A : 8'h20, 1);
        drain();
        total++; if (stalls != s0) begin bad++; $display("FAIL b2b_idle got=%0d want=0", stalls - s0); end
        total++; if (obs_req.size() != 50 || obs_cpl.size() != 50) begin bad++; $display("FAIL b2b_split got=%0d/%0d want=50/50", obs_req.size(), obs_cpl.size()); end
        total++; if (req_cnt !== exp_req_n || cpl_cnt !== exp_cpl_n) begin bad++; $display("FAIL b2b_cnt got=%0d/%0d want=%0d/%0d", req_cnt, cpl_cnt, exp_req_n, exp_cpl_n); end
    endtask

    task automatic test_random();
        logic [7:0] fts [9];
        int nerr;
        fts = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h0A, 8'h4A, 8'h30, 8'h34, 8'h04};
        clear_sb();
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 60; p++) send_pkt(fts[$urandom_range(0, 8)], int'($urandom_range(1, 4)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    req_if.tready = ($urandom_range(0, 1) == 1);
                    cpl_if.tready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        total++; if (obs_req.size() != exp_req.size() || obs_cpl.size() != exp_cpl.size())
            begin bad++; $display("FAIL rnd_sizes got=%0d/%0d want=%0d/%0d", obs_req.size(), obs_cpl.size(), exp_req.size(), exp_cpl.size()); end
        nerr = 0;
        for (int i = 0; i < obs_req.size() && i < exp_req.size(); i++) if (obs_req[i] !== exp_req[i]) nerr++;
        for (int i = 0; i < obs_cpl.size() && i < exp_cpl.size(); i++) if (obs_cpl[i] !== exp_cpl[i]) nerr++;
        total++; if (nerr != 0) begin bad++; $display("FAIL rnd_beats got=%0d wrong want=0", nerr); end
        total++; if (req_cnt !== exp_req_n || cpl_cnt !== exp_cpl_n) begin bad++; $display("FAIL rnd_cnt got=%0d/%0d want=%0d/%0d", req_cnt, cpl_cnt, exp_req_n, exp_cpl_n); end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        clear_sb();
        b = rand_beat(8'h4A, 1'b1, 1'b0);
        in_if.tvalid = 1'b1; in_if.tdata = b.d; in_if.tkeep = b.k; in_if.tlast = b.l; in_if.tuser_vendor = b.u;
        @(negedge clk);
        total++; if (in_if.tready !== 1'b1) begin bad++; $display("FAIL rmid_beat1 got=%b want=1", in_if.tready); end
        @(posedge clk); #1;
        b = rand_beat(8'h4A, 1'b0, 1'b0);
        in_if.tdata = b.d; in_if.tkeep = b.k; in_if.tlast = b.l; in_if.tuser_vendor = b.u;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if ({req_if.tvalid, cpl_if.tvalid, in_if.tready} !== 3'b000) begin bad++; $display("FAIL rmid_async got=%b want=000", {req_if.tvalid, cpl_if.tvalid, in_if.tready}); end
        in_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_sb();
        exp_req_n = 0; exp_cpl_n = 0;
        total++; if (req_cnt !== 32'd0 || cpl_cnt !== 32'd0) begin bad++; $display("FAIL rmid_cnt got=%0d/%0d want=0/0", req_cnt, cpl_cnt); end
        send_pkt(8'h20, 1);
        drain();
        total++; if (obs_req.size() != 1 || obs_cpl.size() != 0) begin bad++; $display("FAIL rmid_route got=%0d/%0d want=1/0", obs_req.size(), obs_cpl.size()); end
        total++; if (obs_req.size() > 0 && obs_req[0] !== exp_req[0]) begin bad++; $display("FAIL rmid_data got=%h want=%h", obs_req[0].d[63:0], exp_req[0].d[63:0]); end
        total++; if (req_cnt !== exp_req_n || cpl_cnt !== exp_cpl_n) begin bad++; $display("FAIL rmid_cnt2 got=%0d/%0d want=%0d/%0d", req_cnt, cpl_cnt, exp_req_n, exp_cpl_n); end
    endtask

    task automatic test_wrap();
        int sent, s0, w;
        logic [DW-1:0] d;
        logic [3:0] e4;
        sent = 0;
        s0 = req4_seen;
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < ((phase == 0) ? 15 : 1); i++) begin
                d = {DW{1'b0}};
                d[31:24] = 8'h20;
                d[63:32] = sent;
                in4_if.tvalid = 1'b1; in4_if.tdata = d; in4_if.tlast = 1'b1;
                @(negedge clk);
                w = 0;
                while (!in4_if.tready && w < 20) begin w++; @(negedge clk); end
                total++; if (w >= 20) begin bad++; $display("FAIL wrap_accept got=stalled want=accepted"); end
                @(posedge clk); #1;
                sent++;
            end
            in4_if.tvalid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            e4 = 4'(sent % 16);
            total++; if (req_cnt4 !== e4) begin bad++; $display("FAIL wrap_cnt%0d got=%0d want=%0d", sent, req_cnt4, e4); end
        end
        total++; if (req4_seen - s0 != 16 || cpl_cnt4 !== 4'd0) begin bad++; $display("FAIL wrap_beats got=%0d/%0d want=16/0", req4_seen - s0, cpl_cnt4); end
    endtask

    initial begin
        in_if.tvalid = 1'b0; in_if.tdata = {DW{1'b0}}; in_if.tkeep = {KW{1'b0}};
        in_if.tlast = 1'b0; in_if.tuser_vendor = {UW{1'b0}};
        in4_if.tvalid = 1'b0; in4_if.tdata = {DW{1'b0}}; in4_if.tkeep = {KW{1'b1}};
        in4_if.tlast = 1'b0; in4_if.tuser_vendor = {UW{1'b0}};
        req_if.tready = 1'b1; cpl_if.tready = 1'b1;
        req4_if.tready = 1'b1; cpl4_if.tready = 1'b1;
        test_reset();
        test_single_mrd();
        test_cpld_then_mwr();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
